// File: rtl/mux_scan_ctrl_if.sv
// Scan-path bundle between the mux sequencer and its environment.
// The sequencer drives the selects and result; the environment drives start, mask and the mux output.
interface mux_scan_ctrl_if;
  logic       start;
  logic [7:0] mask;
  logic       y_in;
  logic       s0;
  logic       s1;
  logic       s2;
  logic [7:0] sample;
  logic       valid;
  logic       busy;

  modport master (
    output start, mask, y_in,
    input  s0, s1, s2, sample, valid, busy
  );

  modport slave (
    input  start, mask, y_in,
    output s0, s1, s2, sample, valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Sequencer for an 8:1 mux: walks the enabled channels in ascending order, samples y_in
// after a settle time on each, and publishes the 8 captured bits with a one-cycle valid.
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input logic          clk,
  input logic          rst,
  mux_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_NEXT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_sel, w_sel_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_mask_q, w_mask_nxt;
  logic [7:0] r_shadow, w_shadow_nxt;
  logic [7:0] r_sample, w_sample_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_busy, w_busy_nxt;
  logic [3:0] w_first;
  logic [3:0] w_after;

  // Lowest enabled channel at or above lo; bit 3 flags that one exists.
  function automatic logic [3:0] next_chan(input logic [7:0] m, input logic [3:0] lo);
    logic [3:0] res;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      if (k >= int'(lo) && m[k]) res = {1'b1, 3'(k)};
    end
    return res;
  endfunction

  assign w_first = next_chan(bus.mask, 4'd0);
  assign w_after = next_chan(r_mask_q, {1'b0, r_sel} + 4'd1);

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_cnt_nxt    = r_cnt;
    w_mask_nxt   = r_mask_q;
    w_shadow_nxt = r_shadow;
    w_sample_nxt = r_sample;
    w_valid_nxt  = 1'b0;
    w_busy_nxt   = r_busy;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_mask_nxt   = bus.mask;
          w_shadow_nxt = 8'h00;
          w_busy_nxt   = 1'b1;
          if (w_first[3]) begin
            w_sel_nxt   = w_first[2:0];
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_DWELL;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DWELL: begin
        w_cnt_nxt = r_cnt + 4'd1;
        // Capture on the last settle cycle so y_in has had DWELL cycles to follow the select.
        if (r_cnt == CNT_LAST) begin
          w_shadow_nxt[r_sel] = bus.y_in;
          w_state_nxt         = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (w_after[3]) begin
          w_sel_nxt   = w_after[2:0];
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_DWELL;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_sample_nxt = r_shadow;
        w_valid_nxt  = 1'b1;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= 3'd0;
      r_cnt    <= 4'd0;
      r_mask_q <= 8'h00;
      r_shadow <= 8'h00;
      r_sample <= 8'h00;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mask_q <= w_mask_nxt;
      r_shadow <= w_shadow_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.s0     = r_sel[2];
  assign bus.s1     = r_sel[1];
  assign bus.s2     = r_sel[0];
  assign bus.sample = r_sample;
  assign bus.valid  = r_valid;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl; the bench plays the mux by deriving y_in from the selects.
module tb_mux_scan_ctrl;
  localparam int DW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] sb_q[$];

  mux_scan_ctrl_if bus();

  mux_scan_ctrl #(.DWELL(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] cur_sel();
    return {bus.s0, bus.s1, bus.s2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input string tag, input logic [7:0] m, input logic [7:0] ymap,
                          input bit toggle, input bit disturb, input logic [7:0] exp_s);
    int n_en, exp_lat, cyc, busy_cyc, nvis, nexp, nvalid;
    logic [2:0] vis[8];
    logic [2:0] exp_vis[8];
    logic [2:0] sel, sel0;
    logic [7:0] exp_pop;
    bit done;
    n_en = $countones(m);
    exp_lat = 2 + n_en * (DW + 1);
    nexp = 0;
    for (int k = 0; k < 8; k++) if (m[k]) begin exp_vis[nexp] = 3'(k); nexp++; end
    cyc = 0; busy_cyc = 0; nvis = 0; done = 0;
    sel0 = cur_sel();
    sb_q.push_back(exp_s);
    bus.mask  = m;
    bus.start = 1'b1;
    bus.y_in  = toggle ? 1'b0 : ymap[sel0];
    while (!done && cyc < 400) begin
      tick();
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
      if (disturb && cyc == 5) begin bus.start = 1'b1; bus.mask = 8'h01; end
      if (disturb && cyc == 6) bus.start = 1'b0;
      sel = cur_sel();
      bus.y_in = toggle ? ~bus.y_in : ymap[sel];
      if (bus.busy) begin
        busy_cyc++;
        if (nvis == 0 || vis[(nvis - 1) % 8] != sel) begin
          if (nvis < 8) vis[nvis] = sel;
          nvis++;
        end
      end
      if (bus.valid) begin
        done = 1;
        check_eq({tag, "_latency"}, cyc, exp_lat);
        check_eq({tag, "_sb_nonempty"}, sb_q.size(), 1);
        exp_pop = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        check_eq({tag, "_sample"}, bus.sample, exp_pop);
      end
    end
    check_eq({tag, "_valid_seen"}, done, 1);
    check_eq({tag, "_busy_cycles"}, busy_cyc, exp_lat - 1);
    if (n_en == 0) begin
      check_eq({tag, "_sel_held"}, cur_sel(), sel0);
    end else begin
      check_eq({tag, "_visits"}, nvis, nexp);
      for (int k = 0; k < nexp && k < nvis; k++) check_eq({tag, "_visit"}, vis[k], exp_vis[k]);
    end
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.valid) nvalid++;
    end
    check_eq({tag, "_no_extra_valid"}, nvalid, 0);
    check_eq({tag, "_sample_hold"}, bus.sample, exp_s);
  endtask

  initial begin
    int nvalid, cyc, v1, v2;
    bus.start = 1'b0;
    bus.mask  = 8'h00;
    bus.y_in  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_sel", cur_sel(), 3'd0);
    check_eq("rst_sample", bus.sample, 8'h00);
    check_eq("rst_valid", bus.valid, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    tick();

    // Full walk with channels 3 and 6 reading high
    run_scan("walk_ff", 8'hFF, 8'h48, 1'b0, 1'b0, 8'h48);

    // Reset partway through a scan
    bus.mask = 8'hFF; bus.y_in = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    repeat (2) tick();
    check_eq("midrst_sel", cur_sel(), 3'd0);
    check_eq("midrst_sample", bus.sample, 8'h00);
    check_eq("midrst_valid", bus.valid, 1'b0);
    check_eq("midrst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.valid || bus.busy) nvalid++;
    end
    check_eq("midrst_idle_after", nvalid, 0);
    check_eq("midrst_sample_after", bus.sample, 8'h00);

    run_scan("sparse_a1", 8'hA1, 8'hFF, 1'b0, 1'b0, 8'hA1);
    run_scan("empty_mask", 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00);
    run_scan("disturb", 8'hFF, 8'h5A, 1'b0, 1'b1, 8'h5A);
    // y_in flips every cycle: ch0 last-dwell value 0, ch1 last-dwell value 1
    run_scan("toggle", 8'h03, 8'h00, 1'b1, 1'b0, 8'h02);

    // Start held high: scans repeat with one IDLE cycle in between
    bus.mask = 8'h01; bus.y_in = 1'b1; bus.start = 1'b1;
    sb_q.push_back(8'h01);
    sb_q.push_back(8'h01);
    v1 = 0; v2 = 0; cyc = 0;
    while (v2 == 0 && cyc < 40) begin
      tick();
      cyc++;
      if (bus.valid) begin
        if (v1 == 0) v1 = cyc; else v2 = cyc;
        check_eq("b2b_sb_nonempty", sb_q.size() > 0, 1);
        check_eq("b2b_sample", bus.sample, (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx);
      end
    end
    bus.start = 1'b0;
    check_eq("b2b_first_valid", v1, 5);
    check_eq("b2b_second_valid", v2, 10);
    repeat (8) tick();
    check_eq("b2b_idle_busy", bus.busy, 1'b0);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
